// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter granting two requesters access to an I/O SRAM
module io_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  cs,
    output logic                  oe,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                state;
    logic                  last_one;
    logic                  pick1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Winner selection: requester 1 wins if alone, or on a tie when requester 0 was granted last
    always_comb begin
        pick1     = req1 && (!req0 || !last_one);
        sel_we    = pick1 ? we1 : we0;
        sel_addr  = pick1 ? addr1 : addr0;
        sel_wdata = pick1 ? wdata1 : wdata0;
    end

    // Transaction FSM; every output is a register so req never reaches the strobes combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_one  <= 1'b1;
            grant     <= 2'b00;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            cs        <= 1'b0;
            we        <= 1'b0;
            oe        <= 1'b0;
            rdata     <= '0;
            address   <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state     <= sel_we ? WR : RD_ADDR;
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        last_one  <= pick1;
                        busy      <= 1'b1;
                        cs        <= 1'b1;
                        we        <= sel_we;
                        oe        <= 1'b0;
                        address   <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end
                end
                WR: begin
                    state <= DONE;
                    cs    <= 1'b0;
                    we    <= 1'b0;
                    ack0  <= grant[0];
                    ack1  <= grant[1];
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                    oe    <= 1'b1;
                end
                RD_DATA: begin
                    state <= DONE;
                    cs    <= 1'b0;
                    oe    <= 1'b0;
                    rdata <= mem_rdata;
                    ack0  <= grant[0];
                    ack1  <= grant[1];
                end
                DONE: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: scoreboard-driven bench for io_bus_arbiter
module tb_io_bus_arbiter;
    logic       clk = 0;
    logic       reset = 0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [5:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       ack0, ack1, busy, cs, oe, we;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [1:0] grant;
    logic [5:0] address;

    typedef struct {
        logic       id;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rdata = 0;
    int         total = 0;
    int         bad = 0;

    io_bus_arbiter dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
        .cs(cs), .oe(oe), .we(we), .address(address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // SRAM stand-in: read data is a fixed function of the address
    assign mem_rdata = {2'b00, address} ^ 8'h2C;

    always #5 clk = ~clk;

    function automatic logic [7:0] st();
        return {grant, busy, cs, we, oe, ack0, ack1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic is_rd, input logic [5:0] a);
        exp_t e;
        if (is_rd) model_rdata = {2'b00, a} ^ 8'h2C;
        e.id = id;
        e.rd = model_rdata;
        sb.push_back(e);
    endtask

    // Scoreboard: each ack pops the oldest expected transaction
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            exp_t e;
            total++;
            if (ack0 && ack1) begin
                bad++;
                $display("FAIL ack_overlap ack0=%b ack1=%b expected one-hot", ack0, ack1);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack ack0=%b ack1=%b expected none", ack0, ack1);
            end else begin
                e = sb.pop_front();
                if ({ack1, ack0} !== (e.id ? 2'b10 : 2'b01) || rdata !== e.rd) begin
                    bad++;
                    $display("FAIL sb_ack got ack=%b%b rdata=%h expected id=%0d rdata=%h",
                             ack1, ack0, rdata, e.id, e.rd);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        model_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        total++;
        if (st() !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl got=%b expected=%b", st(), 8'h00);
        end
        total++;
        if ({rdata, address, mem_wdata} !== 22'h0) begin
            bad++;
            $display("FAIL reset_data got rdata=%h address=%h mem_wdata=%h expected 0", rdata, address, mem_wdata);
        end
        reset = 0;
        model_rdata = 0;
        tick();
        total++;
        if (st() !== 8'h00) begin
            bad++;
            $display("FAIL idle_no_req got=%b expected=%b", st(), 8'h00);
        end
    endtask

    task automatic test_write();
        req0 = 1; we0 = 1; addr0 = 6'h05; wdata0 = 8'hA5;
        push(0, 0, 6'h05);
        tick();
        req0 = 0; addr0 = 6'h2A;
        total++;
        if (st() !== 8'b01_1_1_1_0_0_0 || address !== 6'h05 || mem_wdata !== 8'hA5) begin
            bad++;
            $display("FAIL write_wr got st=%b addr=%h wd=%h expected st=%b addr=05 wd=a5",
                     st(), address, mem_wdata, 8'b01_1_1_1_0_0_0);
        end
        tick();
        total++;
        if (st() !== 8'b01_1_0_0_0_1_0 || address !== 6'h05) begin
            bad++;
            $display("FAIL write_done got st=%b addr=%h expected st=%b addr=05",
                     st(), address, 8'b01_1_0_0_0_1_0);
        end
        tick();
        total++;
        if (st() !== 8'h00) begin
            bad++;
            $display("FAIL write_idle got=%b expected=%b", st(), 8'h00);
        end
    endtask

    task automatic test_read();
        req1 = 1; we1 = 0; addr1 = 6'h10;
        push(1, 1, 6'h10);
        tick();
        req1 = 0;
        total++;
        if (st() !== 8'b10_1_1_0_0_0_0 || address !== 6'h10) begin
            bad++;
            $display("FAIL read_addr got st=%b addr=%h expected st=%b addr=10",
                     st(), address, 8'b10_1_1_0_0_0_0);
        end
        tick();
        total++;
        if (st() !== 8'b10_1_1_0_1_0_0 || address !== 6'h10) begin
            bad++;
            $display("FAIL read_data got st=%b addr=%h expected st=%b addr=10",
                     st(), address, 8'b10_1_1_0_1_0_0);
        end
        tick();
        total++;
        if (st() !== 8'b10_1_0_0_0_0_1 || rdata !== 8'h3C) begin
            bad++;
            $display("FAIL read_done got st=%b rdata=%h expected st=%b rdata=3c",
                     st(), rdata, 8'b10_1_0_0_0_0_1);
        end
        tick();
        total++;
        if (st() !== 8'h00 || rdata !== 8'h3C) begin
            bad++;
            $display("FAIL read_hold got st=%b rdata=%h expected st=00 rdata=3c", st(), rdata);
        end
    endtask

    task automatic test_tie();
        int n = 0;
        do_reset();
        req0 = 1; we0 = 1; addr0 = 6'h0A; wdata0 = 8'h11;
        req1 = 1; we1 = 0; addr1 = 6'h07;
        push(0, 0, 6'h0A);
        push(1, 1, 6'h07);
        push(0, 0, 6'h0A);
        push(1, 1, 6'h07);
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (ack0 || ack1) n++;
        end
        req0 = 0; req1 = 0;
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL tie_timeout got acks=%0d expected 4", n);
        end
        tick();
        tick();
        total++;
        if (st() !== 8'h00 || rdata !== 8'h2B) begin
            bad++;
            $display("FAIL tie_end got st=%b rdata=%h expected st=00 rdata=2b", st(), rdata);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 0; addr0 = 6'h21;
        tick();
        req0 = 0;
        tick();
        total++;
        if (st() !== 8'b01_1_1_0_1_0_0) begin
            bad++;
            $display("FAIL mid_rd_data got=%b expected=%b", st(), 8'b01_1_1_0_1_0_0);
        end
        reset = 1;
        tick();
        total++;
        if (st() !== 8'h00 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got st=%b rdata=%h expected st=00 rdata=00", st(), rdata);
        end
        reset = 0;
        model_rdata = 0;
        repeat (3) tick();
        total++;
        if (st() !== 8'h00) begin
            bad++;
            $display("FAIL mid_after got=%b expected=%b", st(), 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 6'h33; wdata0 = 8'h5C; req1 = 0;
        repeat (4) push(0, 0, 6'h33);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (st() !== 8'b01_1_1_1_0_0_0 || address !== 6'h33 || mem_wdata !== 8'h5C) begin
                bad++;
                $display("FAIL b2b_wr[%0d] got st=%b addr=%h wd=%h expected st=%b addr=33 wd=5c",
                         i, st(), address, mem_wdata, 8'b01_1_1_1_0_0_0);
            end
            tick();
            total++;
            if (st() !== 8'b01_1_0_0_0_1_0) begin
                bad++;
                $display("FAIL b2b_done[%0d] got=%b expected=%b", i, st(), 8'b01_1_0_0_0_1_0);
            end
            if (i == 3) req0 = 0;
            tick();
            total++;
            if (st() !== 8'h00) begin
                bad++;
                $display("FAIL b2b_idle[%0d] got=%b expected=%b", i, st(), 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        tick();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
